// File: rtl/sram_serial_player.sv
// Streams sample words from an asynchronous 16-bit SRAM onto three serial lanes.
// Each frame fetches three consecutive words, then shifts them out MSB-first.
module sram_serial_player #(
  parameter logic [17:0] BASE_ADDR  = 18'd0,
  parameter int unsigned NUM_FRAMES = 1,
  parameter int unsigned READ_WAIT  = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n,
  output logic [17:0] sram_addr,
  inout  logic [15:0] sram_data,
  output logic        serial_clk_o,
  output logic        serial_cyc_o,
  output logic [2:0]  serial_dat_o,
  input  logic [2:0]  serial_dat_i
);

  localparam int unsigned CW = $clog2(READ_WAIT + 2);
  localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } state_t;

  state_t            state_q;
  logic [17:0]       addr_q;
  logic              en_n_q;
  logic [1:0]        word_q;
  logic [CW-1:0]     wait_q;
  logic [2:0][15:0]  lane_q;
  logic [3:0]        bit_q;
  logic              sclk_q;
  logic              cyc_q;
  logic [2:0]        dat_q;
  logic [FW-1:0]     frame_q;
  logic              unused_serial;

  assign sram_data     = 'z;
  assign sram_we_n     = 1'b1;
  assign sram_ce_n     = en_n_q;
  assign sram_oe_n     = en_n_q;
  assign sram_lb_n     = en_n_q;
  assign sram_ub_n     = en_n_q;
  assign sram_addr     = addr_q;
  assign serial_clk_o  = sclk_q;
  assign serial_cyc_o  = cyc_q;
  assign serial_dat_o  = dat_q;
  assign unused_serial = ^serial_dat_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      en_n_q  <= 1'b1;
      word_q  <= '0;
      wait_q  <= '0;
      lane_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cyc_q   <= 1'b0;
      dat_q   <= '0;
      frame_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i && !wb_we_i) begin
            state_q <= FETCH;
            addr_q  <= BASE_ADDR;
            en_n_q  <= 1'b0;
            word_q  <= '0;
            wait_q  <= '0;
          end
        end

        FETCH: begin
          wait_q <= wait_q + CW'(1);
          // Sample edge also releases the enables; the following edge opens the next word.
          if (wait_q == CW'(READ_WAIT)) begin
            lane_q[word_q] <= sram_data;
            en_n_q         <= 1'b1;
          end else if (wait_q == CW'(READ_WAIT + 1)) begin
            wait_q <= '0;
            if (word_q == 2'd2) begin
              state_q <= SHIFT;
              bit_q   <= '0;
              sclk_q  <= 1'b0;
              cyc_q   <= 1'b1;
              dat_q   <= {lane_q[2][15], lane_q[1][15], lane_q[0][15]};
            end else begin
              word_q <= word_q + 2'd1;
              addr_q <= addr_q + 18'd1;
              en_n_q <= 1'b0;
            end
          end
        end

        SHIFT: begin
          if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else if (bit_q == 4'd15) begin
            sclk_q <= 1'b0;
            cyc_q  <= 1'b0;
            dat_q  <= '0;
            if (frame_q == FW'(NUM_FRAMES - 1)) begin
              frame_q <= '0;
              state_q <= IDLE;
            end else begin
              frame_q <= frame_q + FW'(1);
              state_q <= FETCH;
              addr_q  <= addr_q + 18'd1;
              en_n_q  <= 1'b0;
              word_q  <= '0;
              wait_q  <= '0;
            end
          end else begin
            sclk_q <= 1'b0;
            bit_q  <= bit_q + 4'd1;
            dat_q  <= {lane_q[2][14], lane_q[1][14], lane_q[0][14]};
            for (int unsigned k = 0; k < 3; k++) begin
              lane_q[k] <= {lane_q[k][14:0], 1'b0};
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_serial_player.sv
// Bench for sram_serial_player: two instances (1 and 2 frames per start) share one
// SRAM image; expected addresses and lane bits are queued at start and popped by monitors.
module tb_sram_serial_player;

  localparam int unsigned RW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0;
  logic stb = 1'b0;
  logic we  = 1'b0;
  logic [2:0] sdi = '0;

  always #5 clk = ~clk;

  logic        ce_n [2];
  logic        oe_n [2];
  logic        we_n [2];
  logic        lb_n [2];
  logic        ub_n [2];
  logic [17:0] addr [2];
  logic        sclk [2];
  logic        scyc [2];
  logic [2:0]  sdat [2];

  wire  [15:0] sd0;
  wire  [15:0] sd1;
  logic        drv  [2] = '{1'b0, 1'b0};
  logic [15:0] dval [2] = '{16'h0, 16'h0};
  logic [15:0] mem  [0:7];

  assign sd0 = drv[0] ? dval[0] : 'z;
  assign sd1 = drv[1] ? dval[1] : 'z;

  sram_serial_player #(.BASE_ADDR(18'd0), .NUM_FRAMES(1), .READ_WAIT(RW)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
    .sram_lb_n(lb_n[0]), .sram_ub_n(ub_n[0]), .sram_addr(addr[0]), .sram_data(sd0),
    .serial_clk_o(sclk[0]), .serial_cyc_o(scyc[0]), .serial_dat_o(sdat[0]),
    .serial_dat_i(sdi)
  );

  sram_serial_player #(.BASE_ADDR(18'd0), .NUM_FRAMES(2), .READ_WAIT(RW)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
    .sram_lb_n(lb_n[1]), .sram_ub_n(ub_n[1]), .sram_addr(addr[1]), .sram_data(sd1),
    .serial_clk_o(sclk[1]), .serial_cyc_o(scyc[1]), .serial_dat_o(sdat[1]),
    .serial_dat_i(sdi)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // SRAM model: data appears only once the address has been seen stable with
  // ce_n/oe_n low on RW consecutive edges.
  int          st   [2] = '{0, 0};
  logic [17:0] last [2] = '{18'h0, 18'h0};

  always @(posedge clk) begin : sram_model
    int n;
    for (int d = 0; d < 2; d++) begin
      if (!ce_n[d] && !oe_n[d]) begin
        n = (st[d] != 0 && addr[d] == last[d]) ? st[d] + 1 : 1;
        st[d]   <= n;
        last[d] <= addr[d];
        drv[d]  <= (n >= RW);
        dval[d] <= mem[addr[d][2:0]];
      end else begin
        st[d]  <= 0;
        drv[d] <= 1'b0;
      end
    end
  end

  logic [17:0] q_addr [2][$];
  logic [2:0]  q_bit  [2][$];

  logic pclk [2] = '{1'b0, 1'b0};
  logic pce  [2] = '{1'b1, 1'b1};
  logic pcyc [2] = '{1'b0, 1'b0};
  int   lowc [2] = '{0, 0};
  int   cycc [2] = '{0, 0};
  int   gapc [2] = '{0, 0};
  int   rises[2] = '{0, 0};
  bit   gapt [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pclk[d] = 1'b0; pce[d] = 1'b1; pcyc[d] = 1'b0;
        lowc[d] = 0; cycc[d] = 0; gapc[d] = 0; gapt[d] = 1'b0;
      end else begin
        if (!ce_n[d]) begin
          if (pce[d]) begin
            lowc[d] = 1;
            if (q_addr[d].size() == 0) check($sformatf("d%0d_extra_fetch", d), 1, 0);
            else check($sformatf("d%0d_addr", d), addr[d], q_addr[d].pop_front());
            check($sformatf("d%0d_en_pins", d), {oe_n[d], lb_n[d], ub_n[d], we_n[d]}, 4'b0001);
          end else begin
            lowc[d]++;
          end
        end else if (!pce[d]) begin
          check($sformatf("d%0d_en_len", d), lowc[d], RW + 1);
        end

        if (sclk[d] && !pclk[d]) begin
          rises[d]++;
          if (q_bit[d].size() == 0) check($sformatf("d%0d_extra_bit", d), 1, 0);
          else check($sformatf("d%0d_bit", d), sdat[d], q_bit[d].pop_front());
          check($sformatf("d%0d_shift_ctl", d), {scyc[d], ce_n[d], oe_n[d]}, 3'b111);
        end

        if (scyc[d] && !pcyc[d]) begin
          if (gapt[d] && gapc[d] < 20) check($sformatf("d%0d_gap", d), gapc[d], 12);
          gapt[d] = 1'b0;
          cycc[d] = 1;
        end else if (scyc[d]) begin
          cycc[d]++;
        end else if (pcyc[d]) begin
          check($sformatf("d%0d_cyc_len", d), cycc[d], 32);
          check($sformatf("d%0d_idle_out", d), {sclk[d], sdat[d]}, 4'h0);
          gapt[d] = 1'b1;
          gapc[d] = 1;
        end else if (gapt[d]) begin
          gapc[d]++;
        end

        pclk[d] = sclk[d];
        pce[d]  = ce_n[d];
        pcyc[d] = scyc[d];
      end
    end
  end

  task automatic push_expect();
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < d + 1; f++) begin
        for (int k = 0; k < 3; k++) q_addr[d].push_back(18'(3 * f + k));
        for (int b = 15; b >= 0; b--)
          q_bit[d].push_back({mem[3*f+2][b], mem[3*f+1][b], mem[3*f][b]});
      end
    end
  endtask

  task automatic start(input logic w, input bit accept);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w;
    if (accept) push_expect();
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic settle(input string tag, input int r0, input int r1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_addr_left", tag, d), q_addr[d].size(), 0);
      check($sformatf("%s_d%0d_bits_left", tag, d), q_bit[d].size(), 0);
    end
    check($sformatf("%s_d0_rises", tag), rises[0] - r0, 16);
    check($sformatf("%s_d1_rises", tag), rises[1] - r1, 32);
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_ctl", tag, d), {ce_n[d], oe_n[d], we_n[d], lb_n[d], ub_n[d]}, 5'h1F);
      check($sformatf("%s_d%0d_addr", tag, d), addr[d], 18'h0);
      check($sformatf("%s_d%0d_ser", tag, d), {sclk[d], scyc[d], sdat[d]}, 5'h0);
    end
  endtask

  task automatic load(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                      input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = w4; mem[5] = w5;
    mem[6] = 16'hDEAD; mem[7] = 16'hBEEF;
  endtask

  int r0, r1;

  initial begin
    load(16'h0000, 16'hFFFF, 16'h0000, 16'h1111, 16'h2222, 16'h3333);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    r0 = rises[0]; r1 = rises[1];
    start(1'b0, 1'b1);
    settle("single", r0, r1);

    load(16'h8001, 16'h0000, 16'h7FFE, 16'h0001, 16'h8000, 16'hC003);
    r0 = rises[0]; r1 = rises[1];
    start(1'b0, 1'b1);
    settle("order", r0, r1);

    load(16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h0000, 16'h1234, 16'h8000);
    r0 = rises[0]; r1 = rises[1];
    start(1'b0, 1'b1);
    settle("two", r0, r1);

    r0 = rises[0]; r1 = rises[1];
    start(1'b0, 1'b1);
    repeat (20) @(posedge clk);
    start(1'b0, 1'b0);
    settle("busy", r0, r1);
    r0 = rises[0]; r1 = rises[1];
    start(1'b1, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("we_start_d0_rises", rises[0] - r0, 0);
    check("we_start_d1_rises", rises[1] - r1, 0);
    check("we_start_d0_ce", ce_n[0], 1'b1);
    check("we_start_d1_ce", ce_n[1], 1'b1);

    start(1'b0, 1'b1);
    repeat (22) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    for (int d = 0; d < 2; d++) begin
      q_addr[d].delete();
      q_bit[d].delete();
    end

    r0 = rises[0]; r1 = rises[1];
    start(1'b0, 1'b1);
    settle("replay", r0, r1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
